// File: rtl/aes_out_collector.sv
// Output collector for the pipelined AES-256 core: credit-gated issue, valid delay line, show-ahead result FIFO.
// Optional macro AES_COLLECT_SEQ_EN adds a 16-bit issue tag carried with each result on out_seq.
module aes_out_collector #(
   parameter int WIDTH   = 128,
   parameter int LATENCY = 18,
   parameter int DEPTH   = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         core_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   level
`ifdef AES_COLLECT_SEQ_EN
   ,output logic [15:0]             out_seq
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [CW-1:0]      used;
   logic [CW-1:0]      count;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [LATENCY-1:0] dly;
   logic               ready_en;
   logic               issue;
   logic               pop;
   logic               tap;
   logic               full;
   logic               wr_en;
   logic [WIDTH-1:0]   mem [DEPTH];

   // ready_en keeps in_ready low until the first clock after reset release;
   // used counts every credit held by an in-flight or stored result.
   assign full      = (count == CW'(DEPTH));
   assign in_ready  = ready_en && (used < CW'(DEPTH));
   assign issue     = in_valid && in_ready;
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign tap       = dly[LATENCY-1];
   assign wr_en     = tap && !full;
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign level     = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
         dly      <= '0;
         used     <= '0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         ready_en <= 1'b1;
         dly[0]   <= issue;
         for (int i = 1; i < LATENCY; i++) begin
            dly[i] <= dly[i-1];
         end
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         case ({issue, pop})
            2'b10:   used <= used + 1'b1;
            2'b01:   used <= used - 1'b1;
            default: used <= used;
         endcase
      end
   end

   // Result storage is deliberately left unreset; out_data is masked while empty.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= core_data;
      end
   end

`ifdef AES_COLLECT_SEQ_EN
   logic [15:0] seq_cnt;
   logic [15:0] seq_dly [LATENCY];
   logic [15:0] tag_mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_cnt <= '0;
      end else if (issue) begin
         seq_cnt <= seq_cnt + 16'd1;
      end
   end

   // The tag travels alongside the valid bit so it lands with its own result.
   always_ff @(posedge clk) begin
      seq_dly[0] <= seq_cnt;
      for (int i = 1; i < LATENCY; i++) begin
         seq_dly[i] <= seq_dly[i-1];
      end
      if (wr_en) begin
         tag_mem[wr_ptr] <= seq_dly[LATENCY-1];
      end
   end

   assign out_seq = out_valid ? tag_mem[rd_ptr] : '0;
`endif

   // A write arriving at a full FIFO means the credit accounting has broken.
   assert property (@(posedge clk) disable iff (!rst_n) !(tap && full));

endmodule

// File: tb/tb_aes_out_collector.sv
// Self-checking bench for aes_out_collector: table-driven single-issue vectors plus
// multi-cycle sequences for credit exhaustion, streaming, mid-flight reset and (optionally) tag wrap.
module tb_aes_out_collector;

   localparam int WIDTH   = 128;
   localparam int LATENCY = 18;
   localparam int DEPTH   = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] core_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [5:0]       level;
`ifdef AES_COLLECT_SEQ_EN
   logic [15:0]      out_seq;
   logic [15:0]      seq_exp;
   logic [15:0]      last_seq;
   int               seq_err;
   int               seq_pops;
`endif

   int               n_checks = 0;
   int               n_fail   = 0;
   int               cyc      = 0;
   logic             auto_data;
   logic             track;
   logic [WIDTH-1:0] sb [$];

   typedef struct {
      logic [WIDTH-1:0] data;
      int               stall;
      int               exp_lat;
      int               exp_level;
   } vec_t;

   vec_t vecs [4];

   aes_out_collector #(
      .WIDTH   (WIDTH),
      .LATENCY (LATENCY),
      .DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .core_data (core_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level)
`ifdef AES_COLLECT_SEQ_EN
      ,.out_seq  (out_seq)
`endif
   );

   always #5 clk = ~clk;

   // Core output stand-in: a value unique to each cycle, so an issue at cycle c expects pattern(c+LATENCY).
   function automatic logic [WIDTH-1:0] pattern(input int c);
      return {32'(c), 32'hC0DE_0000 + 32'(c), ~32'(c), 32'(c) ^ 32'h5A5A_5A5A};
   endfunction

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic iv, input logic ordy);
      in_valid  = iv;
      out_ready = ordy;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      cyc++;
      if (auto_data) core_data = pattern(cyc);
   endtask

   // One clock; when tracking, every pop is checked against the issue-order scoreboard.
   task automatic tick();
      logic is, po;
      logic [WIDTH-1:0] exp;
      is = in_valid && in_ready;
      po = out_valid && out_ready;
      if (track && po) begin
         if (sb.size() == 0) begin
            checkOutput("pop with nothing expected", out_data, '0);
         end else begin
            exp = sb.pop_front();
            checkOutput("fifo order data", out_data, exp);
         end
`ifdef AES_COLLECT_SEQ_EN
         if (out_seq !== seq_exp) seq_err++;
         last_seq = out_seq;
         seq_exp  = seq_exp + 16'd1;
         seq_pops++;
`endif
      end
      if (track && is) sb.push_back(pattern(cyc + LATENCY));
      advance();
   endtask

   // Asserts reset #1 after an edge, checks outputs clear at once, releases after one edge, then gives the first clock.
   task automatic doReset();
      rst_n = 1'b0;
      #1;
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset level", level, 0);
      checkOutput("reset in_ready", in_ready, 0);
      checkOutput("reset out_data", out_data, 0);
`ifdef AES_COLLECT_SEQ_EN
      checkOutput("reset out_seq", out_seq, 0);
      seq_exp = '0;
`endif
      advance();
      rst_n = 1'b1;
      sb.delete();
      advance();
   endtask

   task automatic drain(input string name, input int bound);
      int guard;
      guard = 0;
      applyStimulus(0, 1);
      while ((sb.size() > 0 || out_valid) && guard < bound) begin
         tick();
         guard++;
      end
      checkOutput(name, sb.size(), 0);
   endtask

   task automatic fillFull();
      applyStimulus(1, 0);
      for (int i = 0; i < 60; i++) tick();
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int lat, issues, drops, maxlev, first_valid, nvalid, stray;

      vecs[0] = '{128'h00112233445566778899AABBCCDDEEFF, 0, LATENCY + 1, 1};
      vecs[1] = '{128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE, 3, LATENCY + 1, 1};
      vecs[2] = '{128'h0000_0000_0000_0000_0000_0000_0000_0001, 1, LATENCY + 1, 1};
      vecs[3] = '{128'hFFFF_0000_FFFF_0000_A5A5_5A5A_3C3C_C3C3, 5, LATENCY + 1, 1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      core_data = '0;
      auto_data = 1'b0;
      track     = 1'b0;
`ifdef AES_COLLECT_SEQ_EN
      seq_exp  = '0;
      last_seq = '0;
      seq_err  = 0;
      seq_pops = 0;
`endif

      $display("[TB] single-issue vectors");
      doReset();
      checkOutput("in_ready first clock after release", in_ready, 1);
      for (int v = 0; v < 4; v++) begin
         core_data = ~vecs[v].data;
         applyStimulus(1, 0);
         tick();
         applyStimulus(0, 0);
         lat = 1;
         while (!out_valid && lat < 40) begin
            core_data = (lat == LATENCY) ? vecs[v].data : ~vecs[v].data;
            tick();
            lat++;
         end
         core_data = ~vecs[v].data;
         checkOutput("issue to out_valid latency", lat, vecs[v].exp_lat);
         checkOutput("captured data", out_data, vecs[v].data);
         for (int s = 0; s < vecs[v].stall; s++) tick();
         checkOutput("data held under backpressure", out_data, vecs[v].data);
         checkOutput("level while held", level, vecs[v].exp_level);
         applyStimulus(0, 1);
         tick();
         applyStimulus(0, 0);
         checkOutput("level after pop", level, 0);
         checkOutput("out_valid after pop", out_valid, 0);
      end

      $display("[TB] credit exhaustion and ordered drain");
      auto_data = 1'b1;
      track     = 1'b1;
      doReset();
      issues = 0;
      applyStimulus(1, 0);
      for (int i = 0; i < 60; i++) begin
         if (in_valid && in_ready) issues++;
         tick();
      end
      checkOutput("issues accepted with no pops", issues, DEPTH);
      checkOutput("in_ready when credits exhausted", in_ready, 0);
      checkOutput("level when full", level, DEPTH);
      applyStimulus(0, 1);
      checkOutput("in_ready during first pop", in_ready, 0);
      tick();
      checkOutput("in_ready after first pop", in_ready, 1);
      drain("all results drained", 60);
      checkOutput("level after drain", level, 0);

      $display("[TB] issue and pop together at used=31");
      doReset();
      fillFull();
      applyStimulus(0, 1);
      tick();
      checkOutput("in_ready at used 31", in_ready, 1);
      applyStimulus(1, 1);
      tick();
      checkOutput("in_ready after issue+pop at 31", in_ready, 1);
      checkOutput("level after issue+pop", level, DEPTH - 2);
      applyStimulus(1, 0);
      tick();
      checkOutput("in_ready after refilling to 32", in_ready, 0);
      drain("drain after credit test", 80);

      $display("[TB] sustained streaming");
      doReset();
      drops = 0; maxlev = 0; first_valid = -1; nvalid = 0;
      applyStimulus(1, 1);
      for (int i = 0; i < 200; i++) begin
         if (!in_ready) drops++;
         if (int'(level) > maxlev) maxlev = int'(level);
         if (out_valid) begin
            nvalid++;
            if (first_valid < 0) first_valid = i;
         end
         tick();
      end
      checkOutput("streaming in_ready drops", drops, 0);
      checkOutput("streaming max level", maxlev, 1);
      checkOutput("streaming first out_valid cycle", first_valid, LATENCY + 1);
      checkOutput("streaming out_valid count", nvalid, 200 - (LATENCY + 1));
      drain("drain after streaming", 40);

      $display("[TB] reset with results in flight and stored");
      doReset();
      applyStimulus(1, 0);
      for (int i = 0; i < 3; i++) tick();
      applyStimulus(0, 0);
      for (int i = 0; i < 7; i++) tick();
      applyStimulus(1, 0);
      for (int i = 0; i < 5; i++) tick();
      applyStimulus(0, 0);
      for (int i = 0; i < 7; i++) tick();
      checkOutput("level before mid-flight reset", level, 3);
      doReset();
      stray = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) stray++;
         tick();
      end
      checkOutput("stray results after reset", stray, 0);
      applyStimulus(1, 0);
      tick();
      applyStimulus(0, 0);
      lat = 1;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      checkOutput("first issue after reset latency", lat, LATENCY + 1);
      drain("first result after reset", 5);

`ifdef AES_COLLECT_SEQ_EN
      $display("[TB] issue tag wrap");
      doReset();
      seq_err  = 0;
      seq_pops = 0;
      applyStimulus(1, 1);
      for (int i = 0; i < 70000; i++) tick();
      applyStimulus(0, 1);
      drain("drain after tag stream", 40);
      checkOutput("tag sequence errors", seq_err, 0);
      checkOutput("tagged results popped", seq_pops, 70000);
      checkOutput("last tag after wrap", last_seq, 16'd4463);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
